// File: rtl/marquee_pkg.sv
// Shared definitions for the scrolling marquee: character codes, FSM states
// and the active-low "all segments off" pattern.
package marquee_pkg;

    localparam logic [4:0] CH_H     = 5'd16;
    localparam logic [4:0] CH_L     = 5'd17;
    localparam logic [4:0] CH_P     = 5'd18;
    localparam logic [4:0] CH_U     = 5'd19;
    localparam logic [4:0] CH_N     = 5'd20;
    localparam logic [4:0] CH_O     = 5'd21;
    localparam logic [4:0] CH_R     = 5'd22;
    localparam logic [4:0] CH_T     = 5'd23;
    localparam logic [4:0] CH_Y     = 5'd24;
    localparam logic [4:0] CH_DASH  = 5'd25;
    localparam logic [4:0] CH_UNDER = 5'd26;
    localparam logic [4:0] CH_BLANK = 5'd31;

    localparam logic [6:0] SEG_OFF  = 7'h7F;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCROLL = 2'd1,
        DWELL  = 2'd2
    } state_t;

endpackage

// File: rtl/scrolling_marquee_if.sv
// Control/write/display bundle between the marquee and whatever loads its text.
// master = controller side, slave = the marquee itself.
interface scrolling_marquee_if #(
    parameter int NUM_DIGITS = 6,
    parameter int MSG_LEN    = 16
);
    localparam int AW = $clog2(MSG_LEN);

    logic                    run;
    logic                    dir;
    logic [1:0]              speed;
    logic                    wr_en;
    logic [AW-1:0]           wr_addr;
    logic [4:0]              wr_data;
    logic [7*NUM_DIGITS-1:0] hex;
    logic [AW-1:0]           offset;
    logic                    wrap;

    modport master (
        output run, dir, speed, wr_en, wr_addr, wr_data,
        input  hex, offset, wrap
    );

    modport slave (
        input  run, dir, speed, wr_en, wr_addr, wr_data,
        output hex, offset, wrap
    );
endinterface

// File: rtl/seg7_char_decoder.sv
// Combinational 5-bit character code -> active-low seven-segment pattern
// (bit0 = a ... bit6 = g). Codes 27..31 and anything unmapped are blank.
module seg7_char_decoder
    import marquee_pkg::*;
(
    input  logic [4:0] code,
    output logic [6:0] seg
);

    // glyph lookup
    always_comb begin
        seg = SEG_OFF;
        case (code)
            5'd0:     seg = 7'h40;
            5'd1:     seg = 7'h79;
            5'd2:     seg = 7'h24;
            5'd3:     seg = 7'h30;
            5'd4:     seg = 7'h19;
            5'd5:     seg = 7'h12;
            5'd6:     seg = 7'h02;
            5'd7:     seg = 7'h78;
            5'd8:     seg = 7'h00;
            5'd9:     seg = 7'h10;
            5'd10:    seg = 7'h08;
            5'd11:    seg = 7'h03;
            5'd12:    seg = 7'h46;
            5'd13:    seg = 7'h21;
            5'd14:    seg = 7'h06;
            5'd15:    seg = 7'h0E;
            CH_H:     seg = 7'h09;
            CH_L:     seg = 7'h47;
            CH_P:     seg = 7'h0C;
            CH_U:     seg = 7'h41;
            CH_N:     seg = 7'h2B;
            CH_O:     seg = 7'h23;
            CH_R:     seg = 7'h2F;
            CH_T:     seg = 7'h07;
            CH_Y:     seg = 7'h11;
            CH_DASH:  seg = 7'h3F;
            CH_UNDER: seg = 7'h77;
            default:  seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/scrolling_marquee.sv
// Scrolling seven-segment marquee: writable MSG_LEN-character buffer shown
// through a NUM_DIGITS window that steps left/right at one of four rates.
// Optional feature macro: MARQUEE_DWELL_EN (hold DWELL_STEPS extra ticks at offset 0).
module scrolling_marquee
    import marquee_pkg::*;
#(
    parameter int NUM_DIGITS       = 6,
    parameter int MSG_LEN          = 16,
    parameter int BASE_STEP_CYCLES = 25_000_000,
    parameter int DWELL_STEPS      = 4
) (
    input  logic                CLOCK_50,
    input  logic                RESET,
    scrolling_marquee_if.slave  bus
);

    localparam int AW = $clog2(MSG_LEN);
    localparam int CW = $clog2(BASE_STEP_CYCLES + 1);

    logic [MSG_LEN-1:0][4:0]    msg;
    logic [AW-1:0]              offset_q;
    logic [AW-1:0]              off_nxt;
    logic                       wrapping;
    logic                       wrap_q;
    logic [CW-1:0]              presc;
    logic [CW-1:0]              period_m1;
    logic                       tick;
    logic                       step;
    logic                       dwell_nxt;
    state_t                     state;
    logic [NUM_DIGITS-1:0][4:0] dig_code;
    logic [NUM_DIGITS-1:0][6:0] dig_seg;
    logic [NUM_DIGITS-1:0][6:0] hex_q;

    // Compare with >= so a speed change that shortens the period fires on the
    // next cycle instead of waiting for the counter to roll over.
    assign period_m1 = CW'((BASE_STEP_CYCLES >> bus.speed) - 1);
    assign tick      = bus.run && (presc >= period_m1);

    // prescaler: counts only while running, clears on every tick
    always_ff @(posedge CLOCK_50) begin
        if (RESET)        presc <= '0;
        else if (tick)    presc <= '0;
        else if (bus.run) presc <= presc + CW'(1);
    end

`ifdef MARQUEE_DWELL_EN
    localparam int DCW = (DWELL_STEPS > 1) ? $clog2(DWELL_STEPS) : 1;

    logic           dwell_act;
    logic [DCW-1:0] dwell_cnt;
    logic           landing;
    logic           dwell_done;

    // While dwelling no step is taken, so dir is only looked at again once
    // the dwell has been left.
    assign step       = tick && !dwell_act;
    assign landing    = step && (off_nxt == '0);
    assign dwell_done = dwell_act && tick && (dwell_cnt == DCW'(DWELL_STEPS - 1));
    assign dwell_nxt  = landing || (dwell_act && !dwell_done);

    // dwell counter: armed on landing at 0, advanced by ticks (frozen when run=0)
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            dwell_act <= 1'b0;
            dwell_cnt <= '0;
        end else if (landing) begin
            dwell_act <= 1'b1;
            dwell_cnt <= '0;
        end else if (dwell_done) begin
            dwell_act <= 1'b0;
        end else if (dwell_act && tick) begin
            dwell_cnt <= dwell_cnt + DCW'(1);
        end
    end
`else
    logic [31:0] dwell_unused;

    assign step         = tick;
    assign dwell_nxt    = 1'b0;
    assign dwell_unused = DWELL_STEPS;
`endif

    // next offset with wrap detection in both directions
    always_comb begin
        off_nxt  = offset_q;
        wrapping = 1'b0;
        if (step) begin
            if (!bus.dir) begin
                if (offset_q == AW'(MSG_LEN - 1)) begin
                    off_nxt  = '0;
                    wrapping = 1'b1;
                end else begin
                    off_nxt = offset_q + AW'(1);
                end
            end else begin
                if (offset_q == '0) begin
                    off_nxt  = AW'(MSG_LEN - 1);
                    wrapping = 1'b1;
                end else begin
                    off_nxt = offset_q - AW'(1);
                end
            end
        end
    end

    // offset register and wrap strobe, aligned with each other
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            offset_q <= '0;
            wrap_q   <= 1'b0;
        end else begin
            offset_q <= off_nxt;
            wrap_q   <= wrapping;
        end
    end

    // message buffer: blank on reset, writes land regardless of run/step
    always_ff @(posedge CLOCK_50) begin
        if (RESET)
            msg <= {MSG_LEN{CH_BLANK}};
        else if (bus.wr_en && (int'(bus.wr_addr) < MSG_LEN))
            msg[bus.wr_addr] <= bus.wr_data;
    end

    // control FSM; the dwell hold itself is tracked by dwell_act so that a
    // pause/resume inside a dwell resumes it without losing the count
    always_ff @(posedge CLOCK_50) begin
        if (RESET)          state <= IDLE;
        else if (!bus.run)  state <= IDLE;
        else if (dwell_nxt) state <= DWELL;
        else                state <= SCROLL;
    end

    // state has no datapath consumer; keep it visible without a dangling net
    logic fsm_unused;
    assign fsm_unused = ^state;

    // window: digit k shows msg[(offset + NUM_DIGITS-1-k) mod MSG_LEN]
    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_dig
        logic [AW:0]   idx_sum;
        logic [AW-1:0] idx;

        assign idx_sum     = {1'b0, offset_q} + (AW+1)'(NUM_DIGITS - 1 - k);
        assign idx         = (idx_sum >= (AW+1)'(MSG_LEN)) ?
                             AW'(idx_sum - (AW+1)'(MSG_LEN)) : idx_sum[AW-1:0];
        assign dig_code[k] = msg[idx];

        seg7_char_decoder u_dec (
            .code (dig_code[k]),
            .seg  (dig_seg[k])
        );
    end

    // registered display outputs
    always_ff @(posedge CLOCK_50) begin
        if (RESET) hex_q <= '1;
        else       hex_q <= dig_seg;
    end

    assign bus.hex    = hex_q;
    assign bus.offset = offset_q;
    assign bus.wrap   = wrap_q;

endmodule
